// File: rtl/counter_pkg.sv
// counter_pkg: direction constants and default sizing for mod_updown_counter.
package counter_pkg;
  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DOWN = 1'b0;
  localparam int DEF_WIDTH = 8;
  localparam int DEF_MODULUS = 256;
endpackage

// File: rtl/mod_step.sv
// mod_step: next count value and wrap detect; saturation only with COUNTER_SAT_EN.
module mod_step
  import counter_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int MODULUS = DEF_MODULUS
) (
  input  logic [WIDTH-1:0] q,
  input  logic             up,
`ifdef COUNTER_SAT_EN
  input  logic             sat,
`endif
  output logic [WIDTH-1:0] q_next,
  output logic             wrap_next
);
  localparam logic [WIDTH-1:0] MAX = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH:0] MOD = (WIDTH + 1)'(MODULUS);
  logic [WIDTH:0] w_sum;
  logic           w_wrap;
  logic [WIDTH-1:0] w_wrapped;
  // one extra bit: up reaches exactly MODULUS, down from 0 sets the MSB
  assign w_sum = (up == DIR_UP) ? {1'b0, q} + 1'b1 : {1'b0, q} - 1'b1;
  assign w_wrap = (up == DIR_UP) ? (w_sum == MOD) : w_sum[WIDTH];
  assign w_wrapped = (up == DIR_UP) ? '0 : MAX;
`ifdef COUNTER_SAT_EN
  assign q_next = w_wrap ? (sat ? q : w_wrapped) : w_sum[WIDTH-1:0];
  assign wrap_next = w_wrap & ~sat;
`else
  assign q_next = w_wrap ? w_wrapped : w_sum[WIDTH-1:0];
  assign wrap_next = w_wrap;
`endif
endmodule

// File: rtl/mod_updown_counter.sv
// mod_updown_counter: modulo up/down counter with clamped load; sat port with COUNTER_SAT_EN.
module mod_updown_counter
  import counter_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int MODULUS = DEF_MODULUS
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  input  logic             en,
  input  logic             up,
`ifdef COUNTER_SAT_EN
  input  logic             sat,
`endif
  output logic [WIDTH-1:0] q,
  output logic             wrap,
  output logic             at_limit
);
  localparam logic [WIDTH-1:0] MAX = WIDTH'(MODULUS - 1);
  logic [WIDTH-1:0] r_q;
  logic             r_wrap;
  logic [WIDTH-1:0] w_q_next;
  logic             w_wrap_next;
  logic [WIDTH-1:0] w_load;
  mod_step #(.WIDTH(WIDTH), .MODULUS(MODULUS)) u_step (
    .q(r_q),
    .up(up),
`ifdef COUNTER_SAT_EN
    .sat(sat),
`endif
    .q_next(w_q_next),
    .wrap_next(w_wrap_next)
  );
  assign w_load = (d > MAX) ? MAX : d;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_q <= '0;
      r_wrap <= 1'b0;
    end else if (load) begin
      r_q <= w_load;
      r_wrap <= 1'b0;
    end else if (en) begin
      r_q <= w_q_next;
      r_wrap <= w_wrap_next;
    end else begin
      r_wrap <= 1'b0;
    end
  end
  assign q = r_q;
  assign wrap = r_wrap;
  assign at_limit = (up == DIR_UP) ? (r_q == MAX) : (r_q == '0);
endmodule

// File: tb/tb_mod_updown_counter.sv
// tb_mod_updown_counter: directed checks on MODULUS 10, 16 and 2 instances.
module tb_mod_updown_counter;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic       reset, load, en, up, sat;
  logic [3:0] d, q;
  logic       wrap, at_limit;
  logic       reset16, load16, en16, up16;
  logic [3:0] d16, q16;
  logic       wrap16, at_limit16;
  logic       reset2, load2, en2, up2;
  logic [0:0] d2, q2;
  logic       wrap2, at_limit2;
  int n_chk = 0;
  int n_pass = 0;
  mod_updown_counter #(.WIDTH(4), .MODULUS(10)) dut (
    .clk(clk), .reset(reset), .load(load), .d(d), .en(en), .up(up),
`ifdef COUNTER_SAT_EN
    .sat(sat),
`endif
    .q(q), .wrap(wrap), .at_limit(at_limit)
  );
  mod_updown_counter #(.WIDTH(4), .MODULUS(16)) dut16 (
    .clk(clk), .reset(reset16), .load(load16), .d(d16), .en(en16), .up(up16),
`ifdef COUNTER_SAT_EN
    .sat(1'b0),
`endif
    .q(q16), .wrap(wrap16), .at_limit(at_limit16)
  );
  mod_updown_counter #(.WIDTH(1), .MODULUS(2)) dut2 (
    .clk(clk), .reset(reset2), .load(load2), .d(d2), .en(en2), .up(up2),
`ifdef COUNTER_SAT_EN
    .sat(1'b0),
`endif
    .q(q2), .wrap(wrap2), .at_limit(at_limit2)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    reset = 1; load = 0; en = 0; up = 1; d = 0; sat = 0;
    reset16 = 1; load16 = 0; en16 = 0; up16 = 1; d16 = 0;
    reset2 = 1; load2 = 0; en2 = 0; up2 = 1; d2 = 0;
    tick();
    check("rst_q", q, 0);
    check("rst_wrap", wrap, 0);
    reset = 0; reset16 = 0; reset2 = 0;
    en = 1; up = 1;
    for (int i = 1; i <= 12; i++) begin
      tick();
      check($sformatf("up_q%0d", i), q, i % 10);
      check($sformatf("up_wrap%0d", i), wrap, (i == 10) ? 1 : 0);
      check($sformatf("up_lim%0d", i), at_limit, (i % 10 == 9) ? 1 : 0);
    end
    en = 0; load = 1; d = 3;
    tick();
    check("ld3_q", q, 3);
    check("ld3_wrap", wrap, 0);
    load = 0; en = 1; up = 0;
    begin
      int exp_q[5] = '{2, 1, 0, 9, 8};
      for (int i = 0; i < 5; i++) begin
        tick();
        check($sformatf("dn_q%0d", i), q, exp_q[i]);
        check($sformatf("dn_wrap%0d", i), wrap, (exp_q[i] == 9) ? 1 : 0);
        check($sformatf("dn_lim%0d", i), at_limit, (exp_q[i] == 0) ? 1 : 0);
      end
    end
    load = 1; en = 0; d = 13;
    tick();
    check("clamp_q", q, 9);
    check("clamp_wrap", wrap, 0);
    en = 1; up = 1; d = 5;
    tick();
    check("ld_en_q", q, 5);
    check("ld_en_wrap", wrap, 0);
    load = 0; en = 0;
    tick();
    check("hold_q", q, 5);
    load = 1; d = 6;
    tick();
    load = 0; en = 1; up = 1;
    tick();
    check("pre_rst_q", q, 7);
    reset = 1; load = 1; d = 4;
    tick();
    check("rst_ld_q", q, 0);
    check("rst_ld_wrap", wrap, 0);
    reset = 0; load = 0; en = 1; up = 0;
    tick();
    check("dir_dn_q", q, 9);
    check("dir_dn_wrap", wrap, 1);
    up = 1;
    tick();
    check("dir_up_q", q, 0);
    check("dir_up_wrap", wrap, 1);
    tick();
    check("dir_up2_q", q, 1);
    check("dir_up2_wrap", wrap, 0);
`ifdef COUNTER_SAT_EN
    load = 1; d = 8; sat = 1;
    tick();
    load = 0; en = 1; up = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("sat_q%0d", i), q, 9);
      check($sformatf("sat_wrap%0d", i), wrap, 0);
      check($sformatf("sat_lim%0d", i), at_limit, 1);
    end
    sat = 0;
    tick();
    check("unsat_q", q, 0);
    check("unsat_wrap", wrap, 1);
`endif
    load16 = 1; d16 = 15;
    tick();
    check("m16_ld_q", q16, 15);
    check("m16_lim", at_limit16, 1);
    load16 = 0; en16 = 1; up16 = 1;
    tick();
    check("m16_q", q16, 0);
    check("m16_wrap", wrap16, 1);
    en2 = 1; up2 = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("m2_q%0d", i), q2, (i % 2 == 0) ? 1 : 0);
      check($sformatf("m2_wrap%0d", i), wrap2, 1);
      up2 = ~up2;
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/mod_updown_counter.md
MOD_UPDOWN_COUNTER -- requirements
Module: mod_updown_counter

Interface
REQ-001 Parameter WIDTH, default 8, counter register width in bits.
REQ-002 Parameter MODULUS, default 256, count range 0..MODULUS-1; legal 2 <= MODULUS <= 2^WIDTH.
REQ-003 Port clk  input  1  single clock; all state SHALL update on its rising edge only.
REQ-004 Port reset  input  1  reset, synchronous and active-high.
REQ-005 Port load  input  1  parallel-load request.
REQ-006 Port d  input  WIDTH  parallel-load value.
REQ-007 Port en  input  1  count enable.
REQ-008 Port up  input  1  direction: 1 = increment, 0 = decrement.
REQ-009 Port sat  input  1  saturate-mode select; present only when COUNTER_SAT_EN is defined.
REQ-010 Port q  output  WIDTH  registered count value.
REQ-011 Port wrap  output  1  registered one-cycle pulse flagging a modulus wrap.
REQ-012 Port at_limit  output  1  combinational; 1 when q == MODULUS-1 and up = 1, or q == 0 and up = 0.

Function
REQ-013 Per-edge priority SHALL be: reset > load > en > hold.
REQ-014 load = 1: q SHALL take d if d <= MODULUS-1, otherwise MODULUS-1 (clamp); en and up ignored; wrap SHALL be 0 next cycle.
REQ-015 load = 0, en = 1, up = 1: q SHALL become q+1, or 0 when q == MODULUS-1.
REQ-016 load = 0, en = 1, up = 0: q SHALL become q-1, or MODULUS-1 when q == 0.
REQ-017 load = 0, en = 0: q SHALL hold; wrap SHALL be 0 next cycle.
REQ-018 wrap SHALL be 1 for exactly the cycle after an edge on which REQ-015 or REQ-016 took its wrap branch, 0 otherwise.
REQ-019 Back-to-back wraps (e.g. MODULUS = 2 with en held) SHALL give wrap = 1 on consecutive cycles.
REQ-020 Direction change SHALL take effect on the same edge as the new up value, with no dead cycle.
REQ-021 Next-value arithmetic SHALL be performed at WIDTH+1 bits so MODULUS = 2^WIDTH wraps without overflow ambiguity.
REQ-022 Latency: load, count and wrap effects SHALL be visible exactly one clock after the sampling edge.

Reset
REQ-023 reset = 1 at an edge SHALL set q = 0 and wrap = 0, overriding load and en.
REQ-024 Reset asserted mid-count or in the same cycle as load SHALL discard the pending operation.
REQ-025 Reset SHALL not be combinationally related to any output; at_limit follows q and up only.

Configuration
REQ-026 Macro COUNTER_SAT_EN defined: port sat SHALL exist; sat = 1 makes REQ-015/016 hold at MODULUS-1 (up) or 0 (down) instead of wrapping, with wrap = 0; sat = 0 behaves as without the macro.
REQ-027 Macro COUNTER_SAT_EN undefined: port sat and saturation logic SHALL be absent; behaviour is REQ-013..022 only.

Structure
REQ-028 Shared package counter_pkg SHALL hold direction constants (DIR_UP = 1, DIR_DOWN = 0) and the default WIDTH/MODULUS constants.
REQ-029 Next-value and wrap-detect logic SHALL be a combinational sub-module mod_step (inputs q, up, sat; outputs q_next, wrap_next), parameterised by WIDTH and MODULUS.
REQ-030 Top level SHALL contain only the priority mux and the q/wrap registers.

Verification (WIDTH = 4, MODULUS = 10 unless stated)
REQ-031 reset 1 cycle, then en = 1, up = 1 for 12 cycles -> q = 1..9, 0, 1, 2; wrap = 1 only in the cycle q = 0.
REQ-032 load = 1, d = 3, then en = 1, up = 0 for 5 cycles -> q = 3, 2, 1, 0, 9, 8; wrap = 1 in the cycle q = 9.
REQ-033 load = 1, d = 13 -> q = 9 (clamped), wrap = 0; load and en both 1 with d = 5 -> q = 5, no increment.
REQ-034 q = 7 counting up, reset and load (d = 4) asserted on the same edge -> q = 0, wrap = 0.
REQ-035 COUNTER_SAT_EN defined, sat = 1, q = 8, en = 1, up = 1 for 4 cycles -> q = 9, 9, 9, 9; wrap never 1; at_limit = 1 from q = 9.
REQ-036 WIDTH = 4, MODULUS = 16, q = 15, up = 1, en = 1 -> q = 0, wrap = 1; MODULUS = 2 with en held -> q toggles, wrap = 1 every cycle.
